// File: rtl/reduce_seq_acc_pkg.sv
// Shared definitions for the group-reducing accumulator: flag bit positions
// and the FSM state encoding.
package reduce_seq_acc_pkg;

  localparam int MF_AGAIN = 3;
  localparam int MF_FIRST = 2;
  localparam int MF_LAST  = 1;
  localparam int MF_VLD   = 0;

  localparam int SF_ABT = 1;
  localparam int SF_BSY = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/reduce_seq_acc.sv
// Collapses each upstream group (first..last beat) into one downstream beat
// carrying the modulo-2^W sum of the data and the beat count.
module reduce_seq_acc
  import reduce_seq_acc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] uc_d0,
  input  logic [3:0]   uc_mflags,
  output logic [1:0]   cu_sflags,
  output logic [W-1:0] cd_d0,
  output logic [W-1:0] cd_d1,
  output logic [3:0]   cd_mflags,
  input  logic [1:0]   dc_sflags,
  output logic         err_proto
);

  // Handshake: a beat moves on any edge where the sender has vld=1 and the
  // receiver's bsy=0; vld and data stay put while bsy=1.
  state_e       state_q, state_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;

  logic uc_vld, uc_first, uc_last;
  logic dc_abt, dc_bsy;
  logic cu_bsy, cd_vld, uc_acc;
  logic unused_again;

  assign uc_vld       = uc_mflags[MF_VLD];
  assign uc_first     = uc_mflags[MF_FIRST];
  assign uc_last      = uc_mflags[MF_LAST];
  assign unused_again = uc_mflags[MF_AGAIN];
  assign dc_abt       = dc_sflags[SF_ABT];
  assign dc_bsy       = dc_sflags[SF_BSY];

  assign cd_vld = (state_q == ST_OUT);
  assign cu_bsy = cd_vld & dc_bsy;
  assign uc_acc = uc_vld & ~cu_bsy;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (dc_abt) begin
      state_d = ST_IDLE;
      sum_d   = '0;
      cnt_d   = '0;
    end else begin
      if (cd_vld && !dc_bsy) state_d = ST_IDLE;
      // An accepted beat can only arrive in ST_OUT once the result is leaving,
      // so a first beat always (re)starts a group regardless of state.
      if (uc_acc) begin
        if (uc_first) begin
          sum_d   = uc_d0;
          cnt_d   = W'(1);
          state_d = uc_last ? ST_OUT : ST_ACC;
          if (state_q == ST_ACC) err_d = 1'b1;
        end else if (state_q == ST_ACC) begin
          sum_d = sum_q + uc_d0;
          cnt_d = cnt_q + W'(1);
          if (uc_last) state_d = ST_OUT;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign cd_d0     = sum_q;
  assign cd_d1     = cnt_q;
  assign err_proto = err_q;

  always_comb begin
    cd_mflags           = '0;
    cd_mflags[MF_VLD]   = cd_vld;
    cd_mflags[MF_FIRST] = cd_vld;
    cd_mflags[MF_LAST]  = cd_vld;
    cd_mflags[MF_AGAIN] = cd_vld & dc_bsy;
    cu_sflags           = '0;
    cu_sflags[SF_ABT]   = dc_abt;
    cu_sflags[SF_BSY]   = cu_bsy;
  end

endmodule

// File: tb/tb_reduce_seq_acc.sv
// Directed and lightly randomised bench for reduce_seq_acc with an
// expected-result queue drained by an output monitor.
module tb_reduce_seq_acc;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] uc_d0;
  logic [3:0]   uc_mflags;
  logic [1:0]   cu_sflags;
  logic [W-1:0] cd_d0;
  logic [W-1:0] cd_d1;
  logic [3:0]   cd_mflags;
  logic [1:0]   dc_sflags;
  logic         err_proto;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  reduce_seq_acc #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uc_d0     (uc_d0),
    .uc_mflags (uc_mflags),
    .cu_sflags (cu_sflags),
    .cd_d0     (cd_d0),
    .cd_d1     (cd_d1),
    .cd_mflags (cd_mflags),
    .dc_sflags (dc_sflags),
    .err_proto (err_proto)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until it is accepted; entered at posedge+1.
  task automatic send_beat(input logic [W-1:0] d, input logic first, input logic last,
                           output int waits);
    uc_d0     = d;
    uc_mflags = {1'b0, first, last, 1'b1};
    waits     = 0;
    @(negedge clk);
    while (cu_sflags[0] && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    chk("accept_timeout", {63'd0, cu_sflags[0]}, 64'd0);
    @(posedge clk);
    #1;
    uc_mflags = 4'b0000;
  endtask

  // accepted-beat counter
  always @(posedge clk)
    if (rst_n && uc_mflags[0] && !cu_sflags[0]) acc_cnt++;

  // scoreboard: pop one expectation per downstream transfer
  always @(negedge clk) begin
    if (rst_n && cd_mflags[0] && !dc_sflags[0] && !dc_sflags[1]) begin
      chk("out_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        chk("out_data", {cd_d0, cd_d1}, exp_q.pop_front());
        chk("out_flags", {60'd0, cd_mflags}, 64'h7);
      end
    end
  end

  initial begin
    int w;
    int acc_before;
    logic [W-1:0] rsum;
    logic [W-1:0] rd;
    int len;

    rst_n     = 1'b0;
    uc_d0     = '0;
    uc_mflags = 4'b0000;
    dc_sflags = 2'b00;
    step();
    step();
    chk("rst_cd_mflags", {60'd0, cd_mflags}, 64'd0);
    chk("rst_cu_sflags", {62'd0, cu_sflags}, 64'd0);
    chk("rst_err", {63'd0, err_proto}, 64'd0);
    chk("rst_sum", {32'd0, cd_d0}, 64'd0);
    chk("rst_cnt", {32'd0, cd_d1}, 64'd0);
    rst_n = 1'b1;
    step();

    // group 5,7,9
    exp_q.push_back({32'd21, 32'd3});
    send_beat(32'd5, 1'b1, 1'b0, w);
    send_beat(32'd7, 1'b0, 1'b0, w);
    send_beat(32'd9, 1'b0, 1'b1, w);
    chk("lat_vld", {63'd0, cd_mflags[0]}, 64'd1);
    chk("lat_d0", {32'd0, cd_d0}, 64'd21);
    step();

    // single beat then back-to-back single beat
    exp_q.push_back({32'd42, 32'd1});
    send_beat(32'd42, 1'b1, 1'b1, w);
    chk("single_vld", {63'd0, cd_mflags[0]}, 64'd1);
    exp_q.push_back({32'd6, 32'd1});
    send_beat(32'd6, 1'b1, 1'b1, w);
    chk("b2b_waits", 64'(w), 64'd0);
    step();

    // downstream busy for 4 cycles with an upstream beat waiting
    dc_sflags = 2'b01;
    exp_q.push_back({32'd33, 32'd2});
    send_beat(32'd11, 1'b1, 1'b0, w);
    send_beat(32'd22, 1'b0, 1'b1, w);
    exp_q.push_back({32'd100, 32'd1});
    uc_d0      = 32'd100;
    uc_mflags  = 4'b0111;
    acc_before = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_cu_bsy", {63'd0, cu_sflags[0]}, 64'd1);
      chk("hold_again", {60'd0, cd_mflags}, 64'hF);
      chk("hold_data", {cd_d0, cd_d1}, {32'd33, 32'd2});
      @(posedge clk);
      #1;
    end
    chk("hold_no_accept", 64'(acc_cnt - acc_before), 64'd0);
    dc_sflags = 2'b00;
    step();
    uc_mflags = 4'b0000;
    chk("release_accept", 64'(acc_cnt - acc_before), 64'd1);
    step();

    // wraparound
    exp_q.push_back({32'd1, 32'd2});
    send_beat(32'hFFFF_FFFF, 1'b1, 1'b0, w);
    send_beat(32'd2, 1'b0, 1'b1, w);
    step();
    step();

    // framing errors
    chk("err_before", {63'd0, err_proto}, 64'd0);
    send_beat(32'd55, 1'b0, 1'b0, w);
    chk("err_set", {63'd0, err_proto}, 64'd1);
    chk("err_no_out", {63'd0, cd_mflags[0]}, 64'd0);
    exp_q.push_back({32'd70, 32'd2});
    send_beat(32'd10, 1'b1, 1'b0, w);
    send_beat(32'd20, 1'b0, 1'b0, w);
    send_beat(32'd30, 1'b1, 1'b0, w);
    send_beat(32'd40, 1'b0, 1'b1, w);
    chk("err_sticky", {63'd0, err_proto}, 64'd1);
    step();

    // abort mid-group, then 3,4
    send_beat(32'd8, 1'b1, 1'b0, w);
    send_beat(32'd9, 1'b0, 1'b0, w);
    dc_sflags = 2'b10;
    @(negedge clk);
    chk("cu_abt", {63'd0, cu_sflags[1]}, 64'd1);
    @(posedge clk);
    #1;
    dc_sflags = 2'b00;
    chk("abt_idle", {60'd0, cd_mflags}, 64'd0);
    exp_q.push_back({32'd7, 32'd2});
    send_beat(32'd3, 1'b1, 1'b0, w);
    send_beat(32'd4, 1'b0, 1'b1, w);
    step();

    // abort discards a pending output
    dc_sflags = 2'b01;
    send_beat(32'd77, 1'b1, 1'b1, w);
    chk("pend_vld", {63'd0, cd_mflags[0]}, 64'd1);
    dc_sflags = 2'b11;
    step();
    dc_sflags = 2'b00;
    chk("abt_pend_drop", {60'd0, cd_mflags}, 64'd0);
    chk("abt_sum_clr", {cd_d0, cd_d1}, 64'd0);
    step();

    // random groups
    for (int g = 0; g < 6; g++) begin
      len  = $urandom_range(1, 4);
      rsum = '0;
      for (int i = 0; i < len; i++) begin
        rd   = W'($urandom);
        rsum = rsum + rd;
        if (i == len - 1) exp_q.push_back({rsum, 32'(len)});
        send_beat(rd, i == 0, i == len - 1, w);
      end
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("drain", 64'(exp_q.size()), 64'd0);

    // reset with a pending output drops it
    dc_sflags = 2'b01;
    send_beat(32'd5, 1'b1, 1'b1, w);
    rst_n = 1'b0;
    step();
    chk("mid_rst_vld", {60'd0, cd_mflags}, 64'd0);
    chk("mid_rst_cu", {62'd0, cu_sflags}, 64'd0);
    chk("mid_rst_err", {63'd0, err_proto}, 64'd0);
    rst_n     = 1'b1;
    dc_sflags = 2'b00;
    step();
    step();
    step();
    chk("mid_rst_no_out", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reduce_seq_acc.md
REDUCE_SEQ_ACC -- requirements
Module: reduce_seq_acc

Interface
REQ-001 Parameter W, default 32, width of data, sum and count paths.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 uc_d0  input  W  upstream beat data.
REQ-005 uc_mflags  input  4  upstream master flags, packed {again, first, last, vld}.
REQ-006 cu_sflags  output  2  upstream slave flags, packed {abt, bsy}.
REQ-007 cd_d0  output  W  group sum.
REQ-008 cd_d1  output  W  group beat count.
REQ-009 cd_mflags  output  4  downstream master flags, packed {again, first, last, vld}.
REQ-010 dc_sflags  input  2  downstream slave flags, packed {abt, bsy}.
REQ-011 err_proto  output  1  sticky framing-error flag.

Function
REQ-012 Block SHALL collapse each upstream group (a first beat through a last beat) into one downstream beat: the sum of the uc_d0 values and the beat count.
REQ-013 An upstream beat SHALL be accepted in a cycle with uc_vld=1 and cu_bsy=0; uc_again is ignored.
REQ-014 A downstream beat SHALL transfer in a cycle with cd_vld=1 and dc_bsy=0.
REQ-015 States SHALL be ST_IDLE, ST_ACC and ST_OUT.
REQ-016 In ST_IDLE, an accepted beat with first=1 and last=0 SHALL load sum=uc_d0 and cnt=1, then go to ST_ACC.
REQ-017 In ST_IDLE, an accepted beat with first=1 and last=1 SHALL load sum=uc_d0 and cnt=1, then go to ST_OUT.
REQ-018 In ST_IDLE, an accepted beat with first=0 SHALL be discarded and set err_proto.
REQ-019 In ST_ACC, an accepted beat SHALL do sum+=uc_d0 and cnt+=1, both modulo 2^W; last=1 SHALL go to ST_OUT.
REQ-020 In ST_ACC, an accepted beat with first=1 SHALL set err_proto and restart the group (sum=uc_d0, cnt=1), applying REQ-016/017 for the next state.
REQ-021 In ST_OUT: cd_vld=1, cd_first=1, cd_last=1, cd_d0=sum, cd_d1=cnt.
REQ-022 cd_d0 and cd_d1 SHALL be registered and held stable while cd_vld=1 and dc_bsy=1.
REQ-023 cd_again SHALL equal cd_vld & dc_bsy.
REQ-024 cu_bsy SHALL be 1 only in ST_OUT with dc_bsy=1; otherwise 0.
REQ-025 In ST_OUT with dc_bsy=0, the output SHALL transfer, and an upstream beat accepted in the same cycle SHALL be processed per the ST_IDLE rules, with no bubble.
REQ-026 Latency: cd_vld SHALL assert the cycle after the last beat is accepted.
REQ-027 cu_abt SHALL equal dc_abt combinationally.
REQ-028 Any cycle with dc_abt=1 SHALL force ST_IDLE and clear sum and cnt on the next edge, and SHALL discard any pending output and any beat accepted that cycle.
REQ-029 err_proto SHALL clear only on reset.

Reset
REQ-030 rst_n=0 sampled at a clk edge SHALL set ST_IDLE, sum=0, cnt=0 and err_proto=0; cd_vld, cd_first, cd_last and cd_again SHALL then be 0 and cu_bsy 0.
REQ-031 Reset mid-group or with a pending output SHALL drop that group without emitting it.

Structure
REQ-032 Shared package SHALL hold the flag bit positions (MF_AGAIN=3, MF_FIRST=2, MF_LAST=1, MF_VLD=0, SF_ABT=1, SF_BSY=0) and the state encoding.
REQ-033 Single module; no sub-module required.

Verification (W=32)
REQ-034 Group 5,7,9 (first on 5, last on 9), dc_bsy=0 -> one beat cd_d0=21, cd_d1=3, first=last=1, the cycle after 9 is accepted.
REQ-035 Single beat first=last=1, d0=42 -> cd_d0=42, cd_d1=1; next group, presented back-to-back, accepted with no idle cycle.
REQ-036 Output pending, dc_bsy=1 for 4 cycles -> cu_bsy=1 and cd_again=1 throughout, cd_d0/d1 stable, no upstream beat accepted.
REQ-037 Group 0xFFFFFFFF,2 -> cd_d0=1 (wrap), cd_d1=2.
REQ-038 Beat with first=0 in ST_IDLE, then a first beat inside a group -> err_proto=1 after the first error; the restarted group sums only from the new first beat.
REQ-039 dc_abt=1 mid-group, then group 3,4 -> no output for the aborted group; then cd_d0=7, cd_d1=2.
